// File: rtl/cla_pipe_adder_pkg.sv
// ============================================================================
// Module : cla_pkg
// Brief  : Shared block width, nibble type and P/G helper for the CLA pipe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cla_pkg;

   localparam int CLA_BLK = 4;

   typedef logic [CLA_BLK-1:0] blk_t;

   // Returns {P, G} for one lookahead block.
   function automatic logic [2*CLA_BLK-1:0] blk_pg(input blk_t a, input blk_t b);
      return {a ^ b, a & b};
   endfunction

endpackage

`default_nettype wire

// File: rtl/cla_pipe_adder_if.sv
// ============================================================================
// Module : cla_pipe_adder_if
// Brief  : Valid/ready operand and result bus of the pipelined CLA adder.
//          Optional sub select exists only when CLA_SUB_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cla_pipe_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef CLA_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
`ifdef CLA_SUB_EN
      output sub,
`endif
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
`ifdef CLA_SUB_EN
      input  sub,
`endif
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

endinterface

`default_nettype wire

// File: rtl/cla_pipe_adder_nibble_stage.sv
// ============================================================================
// Module : cla_nibble_stage
// Brief  : Combinational 4-bit carry-lookahead block; also exposes the carry
//          into bit 3 so the top block can derive signed overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_nibble_stage
   import cla_pkg::*;
(
   input  blk_t a_i,
   input  blk_t b_i,
   input  logic ci_i,
   output blk_t s_o,
   output logic co_o,
   output logic c3_o
);
   logic [2*CLA_BLK-1:0] w_pg;
   blk_t                 w_p;
   blk_t                 w_g;
   logic [CLA_BLK:0]     w_c;

   assign w_pg = blk_pg(a_i, b_i);
   assign w_p  = w_pg[2*CLA_BLK-1:CLA_BLK];
   assign w_g  = w_pg[CLA_BLK-1:0];

   // Every carry is flattened directly from ci, never rippled.
   assign w_c[0] = ci_i;
   assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | ((&w_p) & w_c[0]);

   assign s_o  = w_p ^ w_c[CLA_BLK-1:0];
   assign co_o = w_c[CLA_BLK];
   assign c3_o = w_c[CLA_BLK-1];

endmodule

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
// ============================================================================
// Module : cla_pipe_adder
// Brief  : Carry-pipelined CLA adder, one 4-bit block resolved per stage,
//          valid/ready streaming. Define CLA_SUB_EN to enable subtraction.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   cla_pipe_adder_if.slave bus
);
   localparam int NBLK = WIDTH / CLA_BLK;

   logic             w_advance;
   logic [WIDTH-1:0] w_ent_b;
   logic             w_ent_c;

   logic [NBLK-1:0]  w_vld;
   logic [NBLK-1:0]  w_cy;
   logic             w_vin [NBLK];
   logic             w_co  [NBLK];
   logic             w_c3  [NBLK];
   logic [WIDTH-1:0] w_sum [NBLK];
   logic [WIDTH-1:0] w_opa [NBLK];
   logic [WIDTH-1:0] w_opb [NBLK];
   logic             ovf_q;

   // Whole pipe moves in lockstep; a full, unaccepted output freezes it.
   assign w_advance = !w_vld[NBLK-1] || bus.out_ready;

`ifdef CLA_SUB_EN
   assign w_ent_b = bus.sub ? ~bus.b : bus.b;
   assign w_ent_c = bus.sub ? 1'b1   : bus.cin;
`else
   assign w_ent_b = bus.b;
   assign w_ent_c = bus.cin;
`endif

   for (genvar k = 0; k < NBLK; k++) begin : g_stage
      logic             vin;
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic             src_c;
      logic [WIDTH-1:0] sum_d;
      blk_t             nib_s;
      logic             vld_q;
      logic             cy_q;
      logic [WIDTH-1:0] sum_q;
      logic [WIDTH-1:0] opa_q;
      logic [WIDTH-1:0] opb_q;

      // Resolved nibbles enter at the top and shift down; after the last
      // stage block 0 sits at the bottom. Pending operands shift down too.
      if (k == 0) begin : g_head
         assign vin   = bus.in_valid;
         assign src_a = bus.a;
         assign src_b = w_ent_b;
         assign src_c = w_ent_c;
         assign sum_d = WIDTH'(nib_s) << (WIDTH - CLA_BLK);
      end else begin : g_body
         assign vin   = w_vld[k-1];
         assign src_a = w_opa[k-1];
         assign src_b = w_opb[k-1];
         assign src_c = w_cy[k-1];
         assign sum_d = {nib_s, w_sum[k-1][WIDTH-1:CLA_BLK]};
      end

      cla_nibble_stage u_nibble (
         .a_i  (src_a[CLA_BLK-1:0]),
         .b_i  (src_b[CLA_BLK-1:0]),
         .ci_i (src_c),
         .s_o  (nib_s),
         .co_o (w_co[k]),
         .c3_o (w_c3[k])
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            sum_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
         end else if (w_advance) begin
            vld_q <= vin;
            if (vin) begin
               cy_q  <= w_co[k];
               sum_q <= sum_d;
               opa_q <= src_a >> CLA_BLK;
               opb_q <= src_b >> CLA_BLK;
            end
         end
      end

      assign w_vin[k] = vin;
      assign w_vld[k] = vld_q;
      assign w_cy[k]  = cy_q;
      assign w_sum[k] = sum_q;
      assign w_opa[k] = opa_q;
      assign w_opb[k] = opb_q;
   end

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (w_advance && w_vin[NBLK-1]) begin
         ovf_q <= w_co[NBLK-1] ^ w_c3[NBLK-1];
      end
   end

   assign bus.in_ready  = w_advance;
   assign bus.out_valid = w_vld[NBLK-1];
   assign bus.sum       = w_sum[NBLK-1];
   assign bus.cout      = w_cy[NBLK-1];
   assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
// ============================================================================
// Module : tb_cla_pipe_adder
// Brief  : Scoreboard bench for cla_pipe_adder (WIDTH=16 and WIDTH=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla_pipe_adder;
   localparam int W  = 16;
   localparam int NB = W / 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           acc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_vec;
   int   n_err;
   bit   chk_lat;
   exp_t sb [$];

   cla_pipe_adder_if #(.WIDTH(W)) bus  ();
   cla_pipe_adder_if #(.WIDTH(4)) bus4 ();

   cla_pipe_adder #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   cla_pipe_adder #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sb_, input int acc);
      exp_t         m;
      logic [W-1:0] bb;
      logic         c;
      logic [W:0]   full;
      bb     = sb_ ? ~b : b;
      c      = sb_ ? 1'b1 : ci;
      full   = {1'b0, a} + {1'b0, bb} + (W+1)'(c);
      m.sum  = full[W-1:0];
      m.cout = full[W];
      m.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      m.acc  = acc;
      return m;
   endfunction

   // Result monitor: one handshake per negedge with out_valid && out_ready.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: got sum=%h, required no result", bus.sum);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({bus.sum, bus.cout, bus.ovf} !== {e.sum, e.cout, e.ovf}) begin
               n_err++;
               $display("FAIL result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                        bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
            end
            if (chk_lat) begin
               n_vec++;
               if (cyc - e.acc != NB) begin
                  n_err++;
                  $display("FAIL latency: got %0d cycles, required %0d", cyc - e.acc, NB);
               end
            end
         end
      end
   end

   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb_);
      int guard;
      guard = 0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = ci;
`ifdef CLA_SUB_EN
      bus.sub      = sb_;
`endif
      @(negedge clk);
      while (!bus.in_ready) begin
         guard++;
         if (guard > 50) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0, required 1 within 50 cycles");
            return;
         end
         @(negedge clk);
      end
      sb.push_back(model(a, b, ci, sb_, cyc));
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if ({bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, required 1 0 0000 0 0",
                  bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
      end
      n_vec++;
      if ({bus4.in_ready, bus4.out_valid, bus4.sum} !== {1'b1, 1'b0, 4'h0}) begin
         n_err++;
         $display("FAIL reset_state_w4: got rdy=%b vld=%b sum=%h, required 1 0 0",
                  bus4.in_ready, bus4.out_valid, bus4.sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      chk_lat = 1'b1;
      send_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      idle();
      drain();
      send_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      send_op(16'h1234, 16'h4321, 1'b1, 1'b0);
      send_op(16'h8000, 16'h8000, 1'b0, 1'b0);
      send_op(16'h0000, 16'h0000, 1'b1, 1'b0);
      idle();
      drain();
   endtask

   task automatic test_back_to_back();
      chk_lat = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      end
      idle();
      drain();
   endtask

   task automatic test_stall();
      chk_lat = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               send_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            end
            idle();
         end
         begin
            logic [W-1:0] held;
            repeat (6) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               if (s == 0) held = bus.sum;
               n_vec++;
               if ({bus.in_ready, bus.out_valid, bus.sum} !== {1'b0, 1'b1, held}) begin
                  n_err++;
                  $display("FAIL stall_hold: got rdy=%b vld=%b sum=%h, required 0 1 %h",
                           bus.in_ready, bus.out_valid, bus.sum, held);
               end
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
   endtask

   task automatic test_reset_inflight();
      chk_lat = 1'b1;
      send_op(16'h1111, 16'h2222, 1'b0, 1'b0);
      send_op(16'h3333, 16'h4444, 1'b0, 1'b0);
      send_op(16'h5555, 16'h6666, 1'b0, 1'b0);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({bus.out_valid, bus.in_ready, bus.sum, bus.cout} !== {1'b0, 1'b1, 16'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_inflight: got vld=%b rdy=%b sum=%h cout=%b, required 0 1 0000 0",
                  bus.out_valid, bus.in_ready, bus.sum, bus.cout);
      end
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_op(16'hABCD, 16'h1111, 1'b0, 1'b0);
      idle();
      drain();
   endtask

`ifdef CLA_SUB_EN
   task automatic test_sub();
      chk_lat = 1'b1;
      send_op(16'h0005, 16'h0007, 1'b0, 1'b1);
      send_op(16'h0007, 16'h0005, 1'b0, 1'b1);
      send_op(16'h8000, 16'h0001, 1'b1, 1'b1);
      send_op(16'h1234, 16'h0001, 1'b1, 1'b0);
      idle();
      drain();
   endtask
`endif

   task automatic test_w4();
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b1;
      bus4.a        = 4'hF;
      bus4.b        = 4'h1;
      bus4.cin      = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL w4_accept: got rdy=%b vld=%b, required 1 0", bus4.in_ready, bus4.out_valid);
      end
      @(posedge clk);
      #1;
      bus4.a = 4'h7;
      bus4.b = 4'h1;
      @(negedge clk);
      n_vec++;
      if ({bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf} !== {1'b1, 4'h0, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL w4_first: got vld=%b sum=%h cout=%b ovf=%b, required 1 0 1 0",
                  bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf);
      end
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf} !== {1'b1, 4'h8, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL w4_second: got vld=%b sum=%h cout=%b ovf=%b, required 1 8 0 1",
                  bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf);
      end
      @(negedge clk);
      n_vec++;
      if (bus4.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL w4_bubble: got vld=%b, required 0", bus4.out_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc            = 0;
      n_vec          = 0;
      n_err          = 0;
      chk_lat        = 1'b0;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.cin        = 1'b0;
      bus.out_ready  = 1'b1;
      bus4.in_valid  = 1'b0;
      bus4.a         = '0;
      bus4.b         = '0;
      bus4.cin       = 1'b0;
      bus4.out_ready = 1'b1;
`ifdef CLA_SUB_EN
      bus.sub        = 1'b0;
      bus4.sub       = 1'b0;
`endif
      repeat (3) @(posedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_reset_inflight();
`ifdef CLA_SUB_EN
      test_sub();
`endif
      test_w4();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
